// File: rtl/gpio_in_conditioner_if.sv
// Pin/GPIOIN bundle between the raw-pin conditioner and the AHB GPIO block.
interface gpio_in_conditioner_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] PIN_IN;
    logic              PARITYSEL;
    logic              HOLD;
    logic [DATA_W:0]   GPIOIN;
    logic              CHANGE;
    logic              STABLE;

    modport master (
        output PIN_IN, PARITYSEL, HOLD,
        input  GPIOIN, CHANGE, STABLE
    );

    modport slave (
        input  PIN_IN, PARITYSEL, HOLD,
        output GPIOIN, CHANGE, STABLE
    );
endinterface

// File: rtl/gpio_in_conditioner.sv
// Synchronise, debounce and parity-tag raw pins into a registered GPIOIN word; no backpressure.
// Latency: SYNC_STAGES + DEBOUNCE_CYCLES + 1 edges; HOLD freezes the output register only.
module gpio_in_conditioner #(
    parameter int DATA_W          = 16,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input logic                  clk,
    input logic                  rst,
    gpio_in_conditioner_if.slave bus
);
    localparam int              CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0][DATA_W-1:0] sync_q;
    logic [DATA_W-1:0]                  deb_q, deb_d;
    logic [DATA_W-1:0][CNT_W-1:0]       cnt_q, cnt_d;
    logic [DATA_W:0]                    gpioin_q, gpioin_d;
    logic                               change_q, change_d;
    logic                               stable;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= bus.PIN_IN;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    // A bit is accepted only after differing on DEBOUNCE_CYCLES consecutive edges.
    always_comb begin
        deb_d  = deb_q;
        cnt_d  = cnt_q;
        stable = 1'b1;
        for (int i = 0; i < DATA_W; i++) begin
            if (sync_q[SYNC_STAGES-1][i] == deb_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                deb_d[i] = sync_q[SYNC_STAGES-1][i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
            stable = stable & (cnt_q[i] == '0);
        end
    end

    always_comb begin
        gpioin_d = gpioin_q;
        change_d = 1'b0;
        if (!bus.HOLD) begin
            gpioin_d = {(^deb_q) ^ bus.PARITYSEL, deb_q};
            change_d = (deb_q != gpioin_q[DATA_W-1:0]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb_q    <= '0;
            cnt_q    <= '0;
            gpioin_q <= '0;
            change_q <= 1'b0;
        end else begin
            deb_q    <= deb_d;
            cnt_q    <= cnt_d;
            gpioin_q <= gpioin_d;
            change_q <= change_d;
        end
    end

    assign bus.GPIOIN = gpioin_q;
    assign bus.CHANGE = change_q;
    assign bus.STABLE = stable;
endmodule

// File: tb/tb_gpio_in_conditioner.sv
// Directed bench for gpio_in_conditioner at default parameters.
module tb_gpio_in_conditioner;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    gpio_in_conditioner_if #(.DATA_W(16)) bus ();

    gpio_in_conditioner #(
        .DATA_W(16),
        .SYNC_STAGES(2),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [16:0] eg;
        logic        ec, es;
        rst = 1'b1;
        bus.PIN_IN = 16'hFFFF;
        bus.PARITYSEL = 1'b0;
        bus.HOLD = 1'b0;
        repeat (3) step();
        total++; if (bus.GPIOIN !== 17'h0) begin bad++; $display("FAIL reset_gpioin got=%h want=%h", bus.GPIOIN, 17'h0); end
        total++; if (bus.CHANGE !== 1'b0) begin bad++; $display("FAIL reset_change got=%b want=0", bus.CHANGE); end
        total++; if (bus.STABLE !== 1'b1) begin bad++; $display("FAIL reset_stable got=%b want=1", bus.STABLE); end
        rst = 1'b0;
        for (int e = 1; e <= 9; e++) begin
            step();
            eg = (e >= 7) ? 17'h0FFFF : 17'h0;
            ec = (e == 7);
            es = !(e >= 3 && e <= 5);
            total++; if (bus.GPIOIN !== eg) begin bad++; $display("FAIL t1_gpioin e=%0d got=%h want=%h", e, bus.GPIOIN, eg); end
            total++; if (bus.CHANGE !== ec) begin bad++; $display("FAIL t1_change e=%0d got=%b want=%b", e, bus.CHANGE, ec); end
            total++; if (bus.STABLE !== es) begin bad++; $display("FAIL t1_stable e=%0d got=%b want=%b", e, bus.STABLE, es); end
        end
    endtask

    task automatic test_odd_parity();
        logic [16:0] eg;
        logic        ec;
        rst = 1'b1;
        bus.PIN_IN = 16'h0000;
        bus.PARITYSEL = 1'b1;
        step();
        rst = 1'b0;
        step();
        total++; if (bus.GPIOIN !== 17'h10000) begin bad++; $display("FAIL t2_zero_odd got=%h want=%h", bus.GPIOIN, 17'h10000); end
        total++; if (bus.CHANGE !== 1'b0) begin bad++; $display("FAIL t2_zero_change got=%b want=0", bus.CHANGE); end
        bus.PIN_IN = 16'h0001;
        for (int e = 1; e <= 8; e++) begin
            step();
            eg = (e >= 7) ? 17'h00001 : 17'h10000;
            ec = (e == 7);
            total++; if (bus.GPIOIN !== eg) begin bad++; $display("FAIL t2_gpioin e=%0d got=%h want=%h", e, bus.GPIOIN, eg); end
            total++; if (bus.CHANGE !== ec) begin bad++; $display("FAIL t2_change e=%0d got=%b want=%b", e, bus.CHANGE, ec); end
        end
    endtask

    task automatic test_glitch();
        logic [16:0] eg;
        logic        ec, es;
        // 3-cycle pulse on bit 3: rejected
        bus.PIN_IN = 16'h0009;
        for (int e = 1; e <= 10; e++) begin
            step();
            if (e == 3) bus.PIN_IN = 16'h0001;
            es = !(e >= 3 && e <= 5);
            total++; if (bus.GPIOIN !== 17'h00001) begin bad++; $display("FAIL t3a_gpioin e=%0d got=%h want=%h", e, bus.GPIOIN, 17'h00001); end
            total++; if (bus.CHANGE !== 1'b0) begin bad++; $display("FAIL t3a_change e=%0d got=%b want=0", e, bus.CHANGE); end
            total++; if (bus.STABLE !== es) begin bad++; $display("FAIL t3a_stable e=%0d got=%b want=%b", e, bus.STABLE, es); end
        end
        // 4-cycle pulse: accepted, then its fall is accepted too
        bus.PIN_IN = 16'h0009;
        for (int e = 1; e <= 12; e++) begin
            step();
            if (e == 4) bus.PIN_IN = 16'h0001;
            eg = (e >= 7 && e <= 10) ? 17'h10009 : 17'h00001;
            ec = (e == 7) || (e == 11);
            es = !((e >= 3 && e <= 5) || (e >= 7 && e <= 9));
            total++; if (bus.GPIOIN !== eg) begin bad++; $display("FAIL t3b_gpioin e=%0d got=%h want=%h", e, bus.GPIOIN, eg); end
            total++; if (bus.CHANGE !== ec) begin bad++; $display("FAIL t3b_change e=%0d got=%b want=%b", e, bus.CHANGE, ec); end
            total++; if (bus.STABLE !== es) begin bad++; $display("FAIL t3b_stable e=%0d got=%b want=%b", e, bus.STABLE, es); end
        end
    endtask

    task automatic test_hold();
        bus.PIN_IN = 16'h0000;
        bus.PARITYSEL = 1'b0;
        repeat (9) step();
        total++; if (bus.GPIOIN !== 17'h00000) begin bad++; $display("FAIL t4_pre got=%h want=%h", bus.GPIOIN, 17'h0); end
        bus.HOLD = 1'b1;
        bus.PIN_IN = 16'hA5A5;
        bus.PARITYSEL = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            step();
            total++; if (bus.GPIOIN !== 17'h00000) begin bad++; $display("FAIL t4_held e=%0d got=%h want=%h", e, bus.GPIOIN, 17'h0); end
            total++; if (bus.CHANGE !== 1'b0) begin bad++; $display("FAIL t4_held_change e=%0d got=%b want=0", e, bus.CHANGE); end
        end
        total++; if (bus.STABLE !== 1'b1) begin bad++; $display("FAIL t4_stable got=%b want=1", bus.STABLE); end
        bus.HOLD = 1'b0;
        step();
        total++; if (bus.GPIOIN !== 17'h1A5A5) begin bad++; $display("FAIL t4_release got=%h want=%h", bus.GPIOIN, 17'h1A5A5); end
        total++; if (bus.CHANGE !== 1'b1) begin bad++; $display("FAIL t4_release_change got=%b want=1", bus.CHANGE); end
        step();
        total++; if (bus.CHANGE !== 1'b0) begin bad++; $display("FAIL t4_pulse_width got=%b want=0", bus.CHANGE); end
        bus.PARITYSEL = 1'b0;
        step();
        total++; if (bus.GPIOIN !== 17'h0A5A5) begin bad++; $display("FAIL t4_parsel got=%h want=%h", bus.GPIOIN, 17'h0A5A5); end
        total++; if (bus.CHANGE !== 1'b0) begin bad++; $display("FAIL t4_parsel_change got=%b want=0", bus.CHANGE); end
    endtask

    task automatic test_reset_mid_debounce();
        logic [16:0] eg;
        logic        ec;
        bus.PIN_IN = 16'hA5A4;
        repeat (4) step();
        total++; if (bus.STABLE !== 1'b0) begin bad++; $display("FAIL t5_counting got=%b want=0", bus.STABLE); end
        total++; if (bus.GPIOIN !== 17'h0A5A5) begin bad++; $display("FAIL t5_before got=%h want=%h", bus.GPIOIN, 17'h0A5A5); end
        rst = 1'b1;
        #1;
        total++; if (bus.GPIOIN !== 17'h0) begin bad++; $display("FAIL t5_async_gpioin got=%h want=%h", bus.GPIOIN, 17'h0); end
        total++; if (bus.STABLE !== 1'b1) begin bad++; $display("FAIL t5_async_stable got=%b want=1", bus.STABLE); end
        step();
        rst = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            step();
            eg = (e >= 7) ? 17'h1A5A4 : 17'h0;
            ec = (e == 7);
            total++; if (bus.GPIOIN !== eg) begin bad++; $display("FAIL t5_gpioin e=%0d got=%h want=%h", e, bus.GPIOIN, eg); end
            total++; if (bus.CHANGE !== ec) begin bad++; $display("FAIL t5_change e=%0d got=%b want=%b", e, bus.CHANGE, ec); end
        end
    endtask

    task automatic test_chatter();
        int lo_seen;
        int hi_seen;
        lo_seen = 0;
        hi_seen = 0;
        for (int e = 0; e < 40; e++) begin
            if (e % 2 == 0) bus.PIN_IN[5] = ~bus.PIN_IN[5];
            step();
            if (bus.STABLE === 1'b0) lo_seen++;
            if (bus.STABLE === 1'b1) hi_seen++;
            total++; if (bus.GPIOIN !== 17'h1A5A4) begin bad++; $display("FAIL t6_gpioin e=%0d got=%h want=%h", e, bus.GPIOIN, 17'h1A5A4); end
            total++; if (bus.CHANGE !== 1'b0) begin bad++; $display("FAIL t6_change e=%0d got=%b want=0", e, bus.CHANGE); end
        end
        total++; if (lo_seen == 0 || hi_seen == 0) begin bad++; $display("FAIL t6_stable_toggle lo=%0d hi=%0d want both nonzero", lo_seen, hi_seen); end
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_odd_parity();
        test_glitch();
        test_hold();
        test_reset_mid_debounce();
        test_chatter();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
